bit_serial_alu_seq: RTL

Bit-serial sequencer that runs a WIDTH-bit AND/OR/ADD/SUB on a single instance of the team's one-bit ALU cell (BitALU), one bit per clock, LSB first. Operands and result move through valid/ready handshakes. The carry is held in a flop between bit steps. It sits between an issuing controller and a result consumer wherever area matters more than latency.

---
 rtl/bit_serial_alu_seq.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/bit_serial_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : bit_serial_alu_seq (with one-bit ALU cell BitALU)
// Purpose  : Bit-serial sequencer running a WIDTH-bit AND/OR/ADD/SUB on one
//            instance of the one-bit ALU cell, one bit per clock, LSB first.
//            Operands arrive and results leave through valid/ready handshakes.
// Ports    : clk, rst (synchronous, active-high)
//            in_valid/in_ready, op[2:0], a/b[WIDTH-1:0]   - operand side
//            out_valid/out_ready, result[WIDTH-1:0],
//            carry_out, overflow, zero                    - result side
// Options  : `define SERIAL_ALU_FLAGS_EN to build the overflow/zero flag logic;
//            when undefined both flag ports are tied to 0.
// Revision : 1.0 - initial release
// ============================================================================

// One-bit ALU cell. SUB is a + ~b + cin; the sequencer seeds cin=1 for SUB.
module BitALU (
    input  logic       a_i,
    input  logic       b_i,
    input  logic       cin_i,
    input  logic [2:0] op_i,
    output logic       r_o,
    output logic       cout_o
);
    logic w_b;

    always_comb begin
        r_o    = 1'b0;
        cout_o = 1'b0;
        w_b    = b_i;
        case (op_i)
            3'b000: r_o = a_i & b_i;
            3'b001: r_o = a_i | b_i;
            3'b010, 3'b011: begin
                w_b    = (op_i == 3'b011) ? ~b_i : b_i;
                r_o    = a_i ^ w_b ^ cin_i;
                cout_o = (a_i & w_b) | (a_i & cin_i) | (w_b & cin_i);
            end
            default: begin
                r_o    = 1'b0;
                cout_o = 1'b0;
            end
        endcase
    end
endmodule

module bit_serial_alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, b_sh_q, res_sh_q, result_q;
    logic [2:0]       op_q;
    logic [CNT_W-1:0] cnt_q;
    logic             carry_q, carry_out_q;
    logic             cell_r, cell_cout;
    logic             last_step;
    logic [WIDTH-1:0] final_res;

    BitALU u_cell (
        .a_i    (a_sh_q[0]),
        .b_i    (b_sh_q[0]),
        .cin_i  (carry_q),
        .op_i   (op_q),
        .r_o    (cell_r),
        .cout_o (cell_cout)
    );

    assign last_step = (state_q == S_RUN) && (cnt_q == C_LAST);
    // Complete result as it will look once the MSB step's bit is shifted in.
    assign final_res = {cell_r, res_sh_q[WIDTH-1:1]};

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_valid) state_d = S_RUN;
            S_RUN:   if (cnt_q == C_LAST) state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
    end

    // Datapath. Published outputs live in their own registers so they keep
    // their last DONE values while the next operation is shifting.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            res_sh_q    <= '0;
            result_q    <= '0;
            op_q        <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            carry_out_q <= 1'b0;
        end else if (state_q == S_IDLE) begin
            if (in_valid) begin
                a_sh_q  <= a;
                b_sh_q  <= b;
                op_q    <= op;
                cnt_q   <= '0;
                carry_q <= (op == 3'b011);
            end
        end else if (state_q == S_RUN) begin
            a_sh_q   <= {1'b0, a_sh_q[WIDTH-1:1]};
            b_sh_q   <= {1'b0, b_sh_q[WIDTH-1:1]};
            res_sh_q <= final_res;
            carry_q  <= cell_cout;
            cnt_q    <= cnt_q + CNT_W'(1);
            if (last_step) begin
                result_q    <= final_res;
                carry_out_q <= cell_cout;
            end
        end
    end

    assign result    = result_q;
    assign carry_out = carry_out_q;

`ifdef SERIAL_ALU_FLAGS_EN
    logic overflow_q, zero_q;
    logic is_arith;

    assign is_arith = (op_q == 3'b010) || (op_q == 3'b011);

    // carry_q during the MSB step is the carry into the MSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
        end else if (last_step) begin
            overflow_q <= is_arith & (carry_q ^ cell_cout);
            zero_q     <= (final_res == '0);
        end
    end

    assign overflow = overflow_q;
    assign zero     = zero_q;
`else
    assign overflow = 1'b0;
    assign zero     = 1'b0;
`endif

endmodule
`default_nettype wire
